// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the 16-bit ALU: decode, register read with writeback bypass,
// RAW scoreboard and a single registered output slot. Define OPSTAGE_IMM_EN for imm5 operands.
module alu_operand_stage #(
    parameter int NREGS   = 8,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic        BNegate,
    output logic [2:0]  Op,
    output logic [2:0]  out_rd
);

    typedef enum logic {EMPTY, FULL} slot_state_t;

    slot_state_t state, state_next;

    logic [15:0]      regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_clr;
    logic [NREGS-1:0] busy_set;
    logic [NREGS-1:0] busy_live;

    logic [2:0]  dec_op;
    logic        dec_bneg;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        use_imm;
    logic [15:0] rs_val;
    logic [15:0] rt_val;
    logic [15:0] b_val;
    logic        stall;
    logic        accept;

    assign dec_op   = in_instr[15:13];
    assign dec_bneg = in_instr[12];
    assign rd       = in_instr[10:8];
    assign rs       = in_instr[7:5];
    assign rt       = in_instr[4:2];

`ifdef OPSTAGE_IMM_EN
    logic [15:0] imm_ext;
    assign use_imm = in_instr[11];
    assign imm_ext = {{11{in_instr[4]}}, in_instr[4:0]};
    assign b_val   = use_imm ? imm_ext : rt_val;
`else
    logic unused_imm_bits;
    assign use_imm         = 1'b0;
    assign unused_imm_bits = ^{in_instr[11], in_instr[1:0]};
    assign b_val           = rt_val;
`endif

    // Reads see a same-cycle writeback; a hardwired R0 overrides even the bypass.
    always_comb begin
        rs_val = regs[rs];
        if (wb_en && wb_addr == rs) rs_val = wb_data;
        if (R0_ZERO && rs == 3'd0) rs_val = '0;
        rt_val = regs[rt];
        if (wb_en && wb_addr == rt) rt_val = wb_data;
        if (R0_ZERO && rt == 3'd0) rt_val = '0;
    end

    always_comb begin
        busy_clr = '0;
        if (wb_en) busy_clr[wb_addr] = 1'b1;
        busy_live = busy & ~busy_clr;
        stall     = busy_live[rs] | (!use_imm & busy_live[rt]);
        in_ready  = !rst && !stall && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        busy_set  = '0;
        if (accept && !(R0_ZERO && rd == 3'd0)) busy_set[rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en && !(R0_ZERO && wb_addr == 3'd0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Set is OR-ed after the clear so a new producer wins over a retiring one.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_live | busy_set;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (!accept && out_ready) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign out_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            A       <= '0;
            B       <= '0;
            BNegate <= 1'b0;
            Op      <= 3'b000;
            out_rd  <= 3'd0;
        end else if (accept) begin
            A       <= rs_val;
            B       <= b_val;
            BNegate <= dec_bneg;
            Op      <= dec_op;
            out_rd  <= rd;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] A;
    logic [15:0] B;
    logic        BNegate;
    logic [2:0]  Op;
    logic [2:0]  out_rd;

    int total = 0;
    int bad   = 0;

    bit [15:0] m_regs [8];
    bit        m_busy [8];
    bit        m_valid;
    bit [15:0] m_a;
    bit [15:0] m_b;
    bit        m_bneg;
    bit [2:0]  m_op;
    bit [2:0]  m_rd;
    logic      obs_ready;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B),
        .BNegate(BNegate), .Op(Op), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [15:0] mk(input int op, input int bneg, input int imm,
                                     input int rd, input int rs, input int rt);
        bit [15:0] w;
        w = '0;
        w[15:13] = 3'(op);
        w[12]    = 1'(bneg);
        w[11]    = 1'(imm);
        w[10:8]  = 3'(rd);
        w[7:5]   = 3'(rs);
        w[4:2]   = 3'(rt);
        return w;
    endfunction

    function automatic bit [15:0] readModel(input int addr, input logic we, input int wa,
                                            input logic [15:0] wd);
        if (addr == 0) return 16'h0000;
        if (we && wa == addr) return wd;
        return m_regs[addr];
    endfunction

    function automatic bit isBusy(input int addr, input logic we, input int wa);
        return m_busy[addr] && !(we && wa == addr);
    endfunction

    task automatic applyStimulus(input logic r, input logic iv, input logic [15:0] instr,
                                 input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                 input logic ordy);
        int rs, rt, rd;
        bit use_imm, exp_ready, acc;
        bit [15:0] va, vb;
        @(negedge clk);
        rst = r; in_valid = iv; in_instr = instr;
        wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
        #1;
        rs = int'(instr[7:5]);
        rt = int'(instr[4:2]);
        rd = int'(instr[10:8]);
        use_imm = 1'b0;
`ifdef OPSTAGE_IMM_EN
        use_imm = instr[11];
`endif
        exp_ready = !r && !isBusy(rs, we, int'(wa)) && !(!use_imm && isBusy(rt, we, int'(wa)))
                    && (!m_valid || ordy);
        obs_ready = in_ready;
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        va = readModel(rs, we, int'(wa), wd);
        vb = use_imm ? {{11{instr[4]}}, instr[4:0]} : readModel(rt, we, int'(wa), wd);
        acc = iv && exp_ready;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 8; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
            m_valid = 0; m_a = 0; m_b = 0; m_bneg = 0; m_op = 0; m_rd = 0;
        end else begin
            if (acc) begin
                m_valid = 1; m_a = va; m_b = vb; m_bneg = instr[12]; m_op = instr[15:13];
                m_rd = instr[10:8];
            end else if (m_valid && ordy) begin
                m_valid = 0;
            end
            if (we) m_busy[wa] = 1'b0;
            if (acc && rd != 0) m_busy[rd] = 1'b1;
            if (we && wa != 0) m_regs[wa] = wd;
        end
        #1;
        checkOutput("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        if (m_valid) begin
            checkOutput("A", {16'b0, A}, {16'b0, m_a});
            checkOutput("B", {16'b0, B}, {16'b0, m_b});
            checkOutput("BNegate", {31'b0, BNegate}, {31'b0, m_bneg});
            checkOutput("Op", {29'b0, Op}, {29'b0, m_op});
            checkOutput("out_rd", {29'b0, out_rd}, {29'b0, m_rd});
        end
    endtask

    initial begin
        bit [15:0] imm_instr;

        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, 0);
        checkOutput("rst_in_ready", {31'b0, obs_ready}, 32'd0);
        checkOutput("rst_A", {16'b0, A}, 32'h0);
        checkOutput("rst_B", {16'b0, B}, 32'h0);
        checkOutput("rst_op_rd", {26'b0, BNegate, Op, out_rd}, 32'h0);

        applyStimulus(0, 0, 16'h0, 1, 3'd1, 16'h0005, 1);
        applyStimulus(0, 0, 16'h0, 1, 3'd2, 16'h0003, 1);

        applyStimulus(0, 1, mk(0, 0, 0, 3, 1, 2), 0, 0, 16'h0, 0);
        checkOutput("issue_A", {16'b0, A}, 32'h0005);
        checkOutput("issue_B", {16'b0, B}, 32'h0003);
        checkOutput("issue_rd", {29'b0, out_rd}, 32'd3);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, mk(1, 1, 0, 4, 1, 2), 0, 0, 16'h0, 0);
            checkOutput("hold_ready", {31'b0, obs_ready}, 32'd0);
            checkOutput("hold_A", {16'b0, A}, 32'h0005);
        end
        applyStimulus(0, 1, mk(1, 1, 0, 4, 1, 2), 0, 0, 16'h0, 1);
        checkOutput("refill_rd", {29'b0, out_rd}, 32'd4);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 1);

        applyStimulus(0, 1, mk(2, 0, 0, 5, 3, 2), 0, 0, 16'h0, 1);
        checkOutput("raw_stall", {31'b0, obs_ready}, 32'd0);
        applyStimulus(0, 1, mk(2, 0, 0, 5, 3, 2), 1, 3'd3, 16'h0008, 1);
        checkOutput("raw_release", {31'b0, obs_ready}, 32'd1);
        checkOutput("raw_A", {16'b0, A}, 32'h0008);

        applyStimulus(0, 1, mk(3, 0, 0, 6, 4, 1), 1, 3'd4, 16'h1234, 1);
        checkOutput("bypass_A", {16'b0, A}, 32'h1234);

        applyStimulus(0, 1, mk(0, 0, 0, 7, 1, 1), 0, 0, 16'h0, 1);
        imm_instr = mk(2, 1, 1, 2, 1, 0);
        imm_instr[4:0] = 5'b11100;
`ifdef OPSTAGE_IMM_EN
        applyStimulus(0, 1, imm_instr, 0, 0, 16'h0, 1);
        checkOutput("imm_ready", {31'b0, obs_ready}, 32'd1);
        checkOutput("imm_B", {16'b0, B}, 32'hFFFC);
`else
        applyStimulus(0, 1, imm_instr, 0, 0, 16'h0, 1);
        checkOutput("imm_stall", {31'b0, obs_ready}, 32'd0);
        applyStimulus(0, 1, imm_instr, 1, 3'd7, 16'h00AA, 1);
        checkOutput("imm_B_reg", {16'b0, B}, 32'h00AA);
`endif

        applyStimulus(0, 1, mk(0, 0, 0, 6, 1, 1), 0, 0, 16'h0, 1);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 0);
        applyStimulus(1, 1, mk(0, 0, 0, 5, 1, 1), 1, 3'd1, 16'hBEEF, 0);
        checkOutput("rst_drop_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(0, 1, mk(0, 0, 0, 0, 6, 1), 0, 0, 16'h0, 1);
        checkOutput("rst_busy_clear", {31'b0, obs_ready}, 32'd1);
        checkOutput("rst_regs_A", {16'b0, A}, 32'h0);
        checkOutput("rst_regs_B", {16'b0, B}, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
                          16'($urandom), $urandom_range(0, 4) < 2, 3'($urandom),
                          16'($urandom), $urandom_range(0, 9) < 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the 16-bit ALU.
- Decodes a 16-bit instruction word and reads two operands from an 8x16 register file, with write-through bypass from writeback.
- Tracks in-flight destination registers in a busy scoreboard and stalls on RAW hazards.
- Presents a registered A/B/BNegate/Op bundle to the ALU through a valid/ready handshake.

Parameters:
- NREGS, 8, register count; fixes address width at 3 bits.
- R0_ZERO, 1, when 1 register 0 reads as 16'h0000 and writes to it are dropped.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  instruction accepted this cycle when in_valid is also high.
- in_instr  in  16  [15:13] Op, [12] BNegate, [11] imm, [10:8] rd, [7:5] rs, [4:2] rt, [4:0] imm5.
- wb_en  in  1  writeback strobe.
- wb_addr  in  3  writeback register.
- wb_data  in  16  writeback value.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  ALU/next stage consumes bundle.
- A  out  16  operand A.
- B  out  16  operand B.
- BNegate  out  1  passed to the ALU.
- Op  out  3  passed to the ALU.
- out_rd  out  3  destination tag for writeback.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - All registers cleared to 0; busy[7:0] cleared.
  - out_valid=0; A, B, out_rd = 0; Op=3'b000; BNegate=0.
  - in_ready is held 0 while rst is high.
  - Reset wins over any simultaneous accept or writeback.
- Register file:
  - Written on a clk edge when wb_en=1 (a write to R0 is dropped if R0_ZERO=1).
  - Reads are combinational with bypass: when wb_en=1 and wb_addr equals the read address in the same cycle, wb_data is used.
- Operand select:
  - A = R[rs].
  - B = R[rt], or sign-extended imm5 when the imm feature is active and imm=1.
- Hazard:
  - stall = busy[rs] or busy[rt used], excluding any register being cleared by the current wb.
  - rt is "used" only when B comes from a register.
  - Busy bits for R0 are never set when R0_ZERO=1.
- Handshake:
  - in_ready = !rst and !stall and (!out_valid or out_ready).
  - Accept = in_valid and in_ready. On accept: the bundle is registered, out_valid=1, and busy[rd] is set.
  - If out_valid and out_ready with no accept, out_valid drops to 0.
  - Latency is 1 cycle from accept to out_valid.
  - Throughput is 1 instruction/cycle when there is no hazard.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Scoreboard:
  - wb_en clears busy[wb_addr].
  - A same-cycle set and clear of the same register resolves to set (the new producer wins).
  - A consumer accepted in the same cycle as the clearing wb sees wb_data via bypass.
- No internal FSM beyond the single output slot: states are EMPTY (out_valid=0) and FULL (out_valid=1).

Optional Feature:
- OPSTAGE_IMM_EN
  - Defined: imm=1 selects B = {{11{in_instr[4]}}, in_instr[4:0]}, and rt is not checked for hazards.
  - Undefined: bit 11 is ignored, B is always R[rt], and rt is always hazard-checked.

Test Plan:
- Reset, then write R1=5 and R2=3 via wb. Issue Op=000, rs=1, rt=2, rd=3 → next cycle out_valid=1, A=0005, B=0003, Op=000, out_rd=3, busy[3]=1.
- Hold out_ready=0 for 3 cycles after issue → in_ready=0, and A/B/Op are unchanged throughout. Raise out_ready → slot drains, then the next instruction is accepted.
- Issue rd=3, then immediately an instruction with rs=3 → in_ready=0 until wb_en=1, wb_addr=3, wb_data=0008. In that same cycle the consumer is accepted, and the next cycle shows A=0008.
- In one cycle, wb writes R4=1234 while an instruction reading rs=4 is accepted → A=1234 (bypass).
- With OPSTAGE_IMM_EN defined and instr imm=1, imm5=5'b11100 → B=FFFC, and busy[rt] is ignored. With the macro undefined → B=R[rt].
- Assert rst while out_valid=1 and busy bits are set → the next cycle out_valid=0, all busy bits=0, and register reads return 0.
